round_timer: RTL and testbench

Parametrised per-round countdown timer for the rhythm-game datapath. It replaces the fixed 4-bit `timing` counter with configurable count width, an on-chip seconds prescaler, pause, early round completion, one-shot and auto-reload modes, and a completed-round counter. It sits between the game FSM, which drives `gameState`, `start` and `skip`, and the score and display logic, which consume `sum`, `cout`, `tick` and `rounds`.

---
 rtl/round_timer_pkg.sv | 17 +
 rtl/tick_gen.sv | 38 +++
 rtl/round_timer.sv | 119 +++++++++++
 tb/tb_round_timer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/round_timer_pkg.sv
// Shared definitions for the round timer: FSM state encodings and the
// default seconds-prescaler values for hardware and simulation builds.
package round_timer_pkg;

    // Round FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // after reset, waiting for the first start
        ST_RUN  = 2'd1,   // counting down
        ST_HOLD = 2'd2,   // paused by gameState = 0
        ST_DONE = 2'd3    // one-shot round finished
    } state_t;

    // Clock cycles per second tick: board clock and fast simulation value.
    localparam int PRESCALE_HW  = 50_000_000;
    localparam int PRESCALE_SIM = 4;

endpackage : round_timer_pkg

// File: rtl/tick_gen.sv
// Seconds prescaler: counts enabled cycles 0..PRESCALE-1.
// The tick output is a combinational wrap strobe. It is high during the
// enabled cycle whose rising edge wraps the count back to zero. The
// parent module registers it.
module tick_gen
    import round_timer_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_HW
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(PRESCALE);
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Prescale counter. A clear wins over counting, and the count is frozen
    // while the enable is low.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking (<=) so every flop samples
        // pre-edge values; blocking here would create order-dependent races.
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + W'(1);
        end
    end

endmodule : tick_gen

// File: rtl/round_timer.sv
// Per-round countdown timer. It has a seconds prescaler, pause/resume,
// early completion via skip, one-shot or auto-reload rounds, and a
// saturating count of completed rounds. All outputs are registered.
module round_timer
    import round_timer_pkg::*;
#(
    parameter int CNT_W    = 4,
    parameter int PRESCALE = PRESCALE_HW,
    parameter int RND_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gameState,
    input  logic             start,
    input  logic             skip,
    input  logic             autoReload,
    input  logic [CNT_W-1:0] roundTime,
    output logic [CNT_W-1:0] sum,
    output logic             cout,
    output logic             tick,
    output logic [RND_W-1:0] rounds,
    output logic             busy
);

    state_t state;
    logic   auto_q;      // autoReload latched at start
    logic   in_round;    // RUN or HOLD
    logic   running;     // prescaler allowed to advance
    logic   wrap;        // prescaler about to wrap this cycle
    logic   skip_ev;     // accepted early completion
    logic   zero_ev;     // zero-length round, ends immediately
    logic   tick_ev;     // second tick that actually takes effect
    logic   end_ev;      // any round end
    logic   to_done;     // round end parks the FSM in DONE
    logic   pre_clr;     // restart the prescaler
    state_t run_state;   // RUN or HOLD as chosen by gameState

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .en   (running),
        .clr  (pre_clr),
        .tick (wrap)
    );

    // Event decode. Priority is start > skip > zero-length end > tick.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned; a missing default infers a latch.
        in_round  = 1'b0;
        running   = 1'b0;
        skip_ev   = 1'b0;
        zero_ev   = 1'b0;
        tick_ev   = 1'b0;
        end_ev    = 1'b0;
        to_done   = 1'b0;
        pre_clr   = 1'b0;
        run_state = ST_HOLD;

        in_round  = (state == ST_RUN) || (state == ST_HOLD);
        running   = in_round && gameState;
        run_state = gameState ? ST_RUN : ST_HOLD;
        skip_ev   = in_round && skip && !start;
        zero_ev   = in_round && !start && (sum == '0);
        tick_ev   = wrap && !start && !skip_ev && !zero_ev;
        end_ev    = skip_ev || zero_ev || (tick_ev && (sum == CNT_W'(1)));
        // A round of length zero always parks in DONE, so cout cannot
        // pulse on every cycle in auto mode.
        to_done   = !auto_q || (sum == '0);
        pre_clr   = start || end_ev;
    end

    // Round FSM with registered sum, rounds and output strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            auto_q <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            tick   <= 1'b0;
            rounds <= '0;
            busy   <= 1'b0;
        end else begin
            cout <= end_ev;
            tick <= tick_ev;
            if (start) begin
                sum    <= roundTime;
                auto_q <= autoReload;
                state  <= run_state;
                busy   <= 1'b1;
                // A restart in the middle of a round keeps the tally.
                if (!in_round) begin
                    rounds <= '0;
                end
            end else if (end_ev) begin
                if (rounds != {RND_W{1'b1}}) begin
                    rounds <= rounds + RND_W'(1);
                end
                if (to_done) begin
                    sum   <= '0;
                    state <= ST_DONE;
                    busy  <= 1'b0;
                end else begin
                    sum   <= roundTime;
                    state <= run_state;
                    busy  <= 1'b1;
                end
            end else if (in_round) begin
                if (tick_ev) begin
                    sum <= sum - CNT_W'(1);
                end
                state <= run_state;
            end
        end
    end

endmodule : round_timer

// File: tb/tb_round_timer.sv
// Self-checking bench for round_timer (PRESCALE=4, CNT_W=4, RND_W=8).
// A cycle-level behavioural model of the round rules is compared with the
// DUT on every falling edge. Directed sequences add literal expectations,
// and a randomized phase follows them.
module tb_round_timer;

    localparam int P  = 4;
    localparam int CW = 4;
    localparam int RW = 8;

    logic          clk         = 1'b0;
    logic          rst_n       = 1'b0;
    logic          game_state  = 1'b0;
    logic          start       = 1'b0;
    logic          skip        = 1'b0;
    logic          auto_reload = 1'b0;
    logic [CW-1:0] round_time  = '0;
    logic [CW-1:0] sum;
    logic          cout;
    logic          tick;
    logic [RW-1:0] rounds;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: is a round active, seconds left, cycles into the
    // current second, mode, completed rounds, and this cycle's strobes.
    bit m_active;
    int m_sum;
    int m_pre;
    bit m_auto;
    int m_rounds;
    bit m_cout;
    bit m_tick;

    round_timer #(
        .CNT_W   (CW),
        .PRESCALE(P),
        .RND_W   (RW)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .gameState (game_state),
        .start     (start),
        .skip      (skip),
        .autoReload(auto_reload),
        .roundTime (round_time),
        .sum       (sum),
        .cout      (cout),
        .tick      (tick),
        .rounds    (rounds),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_active = 1'b0;
        m_sum    = 0;
        m_pre    = 0;
        m_auto   = 1'b0;
        m_rounds = 0;
        m_cout   = 1'b0;
        m_tick   = 1'b0;
    endfunction

    // One rising edge of the round rules.
    function automatic void model_step(input bit gs, input bit st, input bit sk,
                                       input bit au, input int rt);
        bit fin;
        bit zero;
        m_cout = 1'b0;
        m_tick = 1'b0;
        if (st) begin
            if (!m_active) m_rounds = 0;
            m_sum    = rt;
            m_pre    = 0;
            m_auto   = au;
            m_active = 1'b1;
            return;
        end
        if (!m_active) return;
        fin  = 1'b0;
        zero = (m_sum == 0);
        if (sk || zero) begin
            fin = 1'b1;
        end else if (gs) begin
            if (m_pre == P - 1) begin
                m_pre  = 0;
                m_tick = 1'b1;
                if (m_sum == 1) fin = 1'b1;
                else m_sum = m_sum - 1;
            end else begin
                m_pre = m_pre + 1;
            end
        end
        if (fin) begin
            m_cout = 1'b1;
            if (m_rounds < 255) m_rounds = m_rounds + 1;
            if (m_auto && !zero) begin
                m_sum = rt;
                m_pre = 0;
            end else begin
                m_sum    = 0;
                m_active = 1'b0;
            end
        end
    endfunction

    // Compare process: advance the model on each rising edge, check on the falling edge.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step(game_state, start, skip, auto_reload, int'(round_time));
            @(negedge clk);
            if (!rst_n) model_reset();
            check("cmp_sum",    sum,    m_sum);
            check("cmp_cout",   cout,   m_cout);
            check("cmp_tick",   tick,   m_tick);
            check("cmp_busy",   busy,   m_active);
            check("cmp_rounds", rounds, m_rounds);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        skip  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic start_round(input int rt, input bit au, input bit gs);
        round_time  = CW'(rt);
        auto_reload = au;
        game_state  = gs;
        start       = 1'b1;
        step();
        start = 1'b0;
    endtask

    int ncout;
    int nticks;

    initial begin
        // Reset state.
        do_reset();
        check("rst_sum", sum, 0);
        check("rst_busy", busy, 0);
        check("rst_rounds", rounds, 0);
        check("rst_cout", cout, 0);
        check("rst_tick", tick, 0);

        // One-shot countdown of 5 seconds.
        start_round(5, 1'b0, 1'b1);
        check("os_load_sum", sum, 5);
        check("os_load_busy", busy, 1);
        ncout = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (cout) ncout++;
            if (k == 4) check("os_first_tick", tick, 1);
            if ((k % 4 == 0) && (k < 20)) check("os_sum_step", sum, 5 - k / 4);
            if (k == 20) check("os_cout_at_20", cout, 1);
        end
        check("os_cout_count", ncout, 1);
        check("os_end_sum", sum, 0);
        check("os_end_rounds", rounds, 1);
        check("os_end_busy", busy, 0);

        // Auto-reload, 3 seconds per round.
        do_reset();
        start_round(3, 1'b1, 1'b1);
        ncout = 0;
        for (int k = 1; k <= 36; k++) begin
            step();
            if (cout) begin
                ncout++;
                check("ar_cout_period", k % 12, 0);
            end
            if (k == 4)  check("ar_sum_2", sum, 2);
            if (k == 8)  check("ar_sum_1", sum, 1);
            if (k == 12) check("ar_sum_reload", sum, 3);
        end
        check("ar_cout_count", ncout, 3);
        check("ar_rounds_3", rounds, 3);
        check("ar_busy", busy, 1);
        skip = 1'b1;
        for (int i = 0; i < 300; i++) step();
        skip = 1'b0;
        check("ar_sat_rounds", rounds, 255);
        check("ar_sat_cout", cout, 1);
        step();
        check("ar_sat_hold", rounds, 255);
        check("ar_sat_cout_off", cout, 0);

        // Pause at sum=4 with the prescaler at 2.
        do_reset();
        start_round(5, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) step();
        check("pz_sum_before", sum, 4);
        game_state = 1'b0;
        nticks = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (tick) nticks++;
        end
        check("pz_no_ticks", nticks, 0);
        check("pz_sum_frozen", sum, 4);
        check("pz_busy", busy, 1);
        game_state = 1'b1;
        step();
        check("pz_resume_1", tick, 0);
        step();
        check("pz_resume_2", tick, 1);
        check("pz_resume_sum", sum, 3);

        // Skip in a one-shot round at sum=4, then skip in DONE.
        do_reset();
        start_round(5, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) step();
        check("sk_sum_before", sum, 4);
        skip = 1'b1;
        step();
        skip = 1'b0;
        check("sk_cout", cout, 1);
        check("sk_sum", sum, 0);
        check("sk_rounds", rounds, 1);
        check("sk_busy", busy, 0);
        skip = 1'b1;
        step();
        skip = 1'b0;
        check("sk_done_cout", cout, 0);
        check("sk_done_rounds", rounds, 1);

        // roundTime = 0 in auto mode: a single cout, then DONE.
        do_reset();
        start_round(0, 1'b1, 1'b1);
        check("z_busy_start", busy, 1);
        check("z_cout_start", cout, 0);
        step();
        check("z_cout", cout, 1);
        check("z_busy", busy, 0);
        check("z_rounds", rounds, 1);
        ncout = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (cout) ncout++;
        end
        check("z_no_more_cout", ncout, 0);

        // start and skip in the same cycle: start wins.
        round_time  = 4'd5;
        auto_reload = 1'b0;
        start       = 1'b1;
        skip        = 1'b1;
        step();
        start = 1'b0;
        skip  = 1'b0;
        check("ss_cout", cout, 0);
        check("ss_sum", sum, 5);
        check("ss_rounds", rounds, 0);
        step();
        check("ss_cout_after", cout, 0);

        // Asynchronous reset in the middle of a round.
        start_round(5, 1'b1, 1'b1);
        skip = 1'b1;
        step();
        skip = 1'b0;
        check("ar_pre_rounds", rounds, 1);
        for (int k = 0; k < 3; k++) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_sum", sum, 0);
        check("mr_busy", busy, 0);
        check("mr_rounds", rounds, 0);
        check("mr_cout", cout, 0);
        check("mr_tick", tick, 0);
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) step();
        check("mr_idle_busy", busy, 0);
        check("mr_idle_sum", sum, 0);
        start_round(2, 1'b0, 1'b1);
        check("mr_restart_busy", busy, 1);
        check("mr_restart_sum", sum, 2);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            start       = ($urandom % 100) < 3;
            skip        = ($urandom % 100) < 4;
            game_state  = ($urandom % 100) < 85;
            auto_reload = $urandom % 2;
            round_time  = ($urandom % 8 == 0) ? 4'd0 : CW'($urandom_range(1, 6));
            rst_n       = ($urandom % 500) != 0;
            step();
        end
        rst_n = 1'b1;
        start = 1'b0;
        skip  = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_round_timer
